// File: rtl/dcache_pkg.sv
// Shared types and defaults for the dcache memory-port arbiter.
// Owner encoding and the {valid, owner} response tag carried through the read pipeline.
package dcache_pkg;

    localparam int DCACHE_ADDR_W = 15;
    localparam int DCACHE_LINE   = 288;

    typedef enum logic {OWNER_RF, OWNER_DMA} dcache_owner_t;

    typedef struct packed {
        logic          valid;
        dcache_owner_t owner;
    } dcache_tag_t;

    function automatic dcache_tag_t dcache_make_tag(input logic valid, input dcache_owner_t owner);
        dcache_tag_t tag;
        tag.valid = valid;
        tag.owner = owner;
        return tag;
    endfunction

endpackage

// File: rtl/dcache_rsp_tag_pipe.sv
// Fixed-depth shift register of response tags, aligned with the memory read latency.
// Holds while shift_en is low; synchronous clear drops every in-flight tag.
module dcache_rsp_tag_pipe
    import dcache_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        shift_en,
    input  dcache_tag_t tag_in,
    output dcache_tag_t tag_out
);

    dcache_tag_t stage_r [DEPTH];

    // Advance tags toward the head on unfrozen cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= dcache_make_tag(1'b0, OWNER_RF);
            end
        end else if (shift_en) begin
            stage_r[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign tag_out = stage_r[DEPTH-1];

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single dcache memory port between the regfile bus (high) and DMA (low),
// routing read data back by owner. Optional DMA anti-starvation: DCACHE_ARB_STARVE_EN.
module dcache_port_arbiter
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = DCACHE_ADDR_W,
    parameter int LINE       = DCACHE_LINE,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic              rf_req_valid,
    output logic              rf_req_ready,
    input  logic              rf_req_we,
    input  logic [ADDR_W-1:0] rf_req_addr,
    input  logic [LINE-1:0]   rf_req_wdat,
    output logic              rf_rsp_valid,
    output logic [LINE-1:0]   rf_rsp_dat,
    input  logic              dma_req_valid,
    output logic              dma_req_ready,
    input  logic              dma_req_we,
    input  logic [ADDR_W-1:0] dma_req_addr,
    input  logic [LINE-1:0]   dma_req_wdat,
    output logic              dma_rsp_valid,
    output logic [LINE-1:0]   dma_rsp_dat,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE-1:0]   mem_wdat,
    input  logic [LINE-1:0]   mem_rdat
);

    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
        $error("dcache_port_arbiter: MEM_LAT must be 1..4");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("dcache_port_arbiter: STARVE_MAX must be 1..15");
    end

    logic        force_dma_s;
    logic        rf_xfer_s;
    logic        dma_xfer_s;
    logic        rsp_fire_s;
    dcache_tag_t push_tag_s;
    dcache_tag_t head_tag_s;

    assign rf_xfer_s  = rf_req_valid && rf_req_ready;
    assign dma_xfer_s = dma_req_valid && dma_req_ready;

`ifdef DCACHE_ARB_STARVE_EN
    logic [3:0] starve_cnt_r;

    // Count consecutive unfrozen cycles in which a waiting DMA request was denied
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= 4'd0;
        end else if (freeze) begin
            starve_cnt_r <= starve_cnt_r;
        end else if (!dma_req_valid || dma_xfer_s) begin
            starve_cnt_r <= 4'd0;
        end else if (starve_cnt_r != 4'(STARVE_MAX)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign force_dma_s = dma_req_valid && (starve_cnt_r == 4'(STARVE_MAX));
`else
    assign force_dma_s = 1'b0;
`endif

    // Grant selection: at most one ready, none while frozen or in reset
    always_comb begin
        rf_req_ready  = 1'b0;
        dma_req_ready = 1'b0;
        if (reset || freeze) begin
            rf_req_ready  = 1'b0;
            dma_req_ready = 1'b0;
        end else if (force_dma_s) begin
            dma_req_ready = 1'b1;
        end else if (rf_req_valid) begin
            rf_req_ready = 1'b1;
        end else if (dma_req_valid) begin
            dma_req_ready = 1'b1;
        end else begin
            rf_req_ready  = 1'b0;
            dma_req_ready = 1'b0;
        end
    end

    // Drive the memory port from the winner in the grant cycle
    always_comb begin
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = {ADDR_W{1'b0}};
        mem_wdat   = {LINE{1'b0}};
        push_tag_s = dcache_make_tag(1'b0, OWNER_RF);
        case ({rf_xfer_s, dma_xfer_s})
            2'b10: begin
                mem_en     = 1'b1;
                mem_we     = rf_req_we;
                mem_addr   = rf_req_addr;
                mem_wdat   = rf_req_wdat;
                push_tag_s = dcache_make_tag(!rf_req_we, OWNER_RF);
            end
            2'b01: begin
                mem_en     = 1'b1;
                mem_we     = dma_req_we;
                mem_addr   = dma_req_addr;
                mem_wdat   = dma_req_wdat;
                push_tag_s = dcache_make_tag(!dma_req_we, OWNER_DMA);
            end
            default: begin
                mem_en     = 1'b0;
                mem_we     = 1'b0;
                push_tag_s = dcache_make_tag(1'b0, OWNER_RF);
            end
        endcase
    end

    dcache_rsp_tag_pipe #(
        .DEPTH (MEM_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .shift_en (!freeze),
        .tag_in   (push_tag_s),
        .tag_out  (head_tag_s)
    );

    assign rsp_fire_s = head_tag_s.valid && !freeze && !reset;

    // Route the returning read data to its owner only
    always_comb begin
        rf_rsp_valid  = 1'b0;
        dma_rsp_valid = 1'b0;
        rf_rsp_dat    = {LINE{1'b0}};
        dma_rsp_dat   = {LINE{1'b0}};
        if (rsp_fire_s && (head_tag_s.owner == OWNER_DMA)) begin
            dma_rsp_valid = 1'b1;
            dma_rsp_dat   = mem_rdat;
        end else if (rsp_fire_s) begin
            rf_rsp_valid = 1'b1;
            rf_rsp_dat   = mem_rdat;
        end else begin
            rf_rsp_valid  = 1'b0;
            dma_rsp_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed self-checking bench for dcache_port_arbiter with a 2-cycle memory model.
module tb_dcache_port_arbiter;

    localparam int AW = 15;
    localparam int LW = 288;

    logic          clk = 1'b0;
    logic          reset;
    logic          freeze;
    logic          rf_req_valid, rf_req_ready, rf_req_we;
    logic [AW-1:0] rf_req_addr;
    logic [LW-1:0] rf_req_wdat;
    logic          rf_rsp_valid;
    logic [LW-1:0] rf_rsp_dat;
    logic          dma_req_valid, dma_req_ready, dma_req_we;
    logic [AW-1:0] dma_req_addr;
    logic [LW-1:0] dma_req_wdat;
    logic          dma_rsp_valid;
    logic [LW-1:0] dma_rsp_dat;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdat;
    logic [LW-1:0] mem_rdat;
    logic [LW-1:0] md0_r, md1_r;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .rf_req_valid(rf_req_valid), .rf_req_ready(rf_req_ready), .rf_req_we(rf_req_we),
        .rf_req_addr(rf_req_addr), .rf_req_wdat(rf_req_wdat),
        .rf_rsp_valid(rf_rsp_valid), .rf_rsp_dat(rf_rsp_dat),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_we(dma_req_we),
        .dma_req_addr(dma_req_addr), .dma_req_wdat(dma_req_wdat),
        .dma_rsp_valid(dma_rsp_valid), .dma_rsp_dat(dma_rsp_dat),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdat(mem_wdat),
        .mem_rdat(mem_rdat)
    );

    function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
        return {16{3'b101, a}};
    endfunction

    // Memory model: read data appears two unfrozen cycles after the strobe
    always @(posedge clk) begin
        if (!freeze) begin
            md1_r <= md0_r;
            md0_r <= (mem_en && !mem_we) ? pat(mem_addr) : {LW{1'b0}};
        end
    end
    assign mem_rdat = md1_r;

    task automatic check_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rf_req_valid = 1'b0; rf_req_we = 1'b0; rf_req_addr = 15'h0000; rf_req_wdat = {LW{1'b0}};
        dma_req_valid = 1'b0; dma_req_we = 1'b0; dma_req_addr = 15'h0000; dma_req_wdat = {LW{1'b0}};
    endtask

    task automatic check_rsp(input string tag, input logic rv, input logic [LW-1:0] rd,
                             input logic dv, input logic [LW-1:0] dd);
        check_val({tag, "_rf_v"}, LW'(rf_rsp_valid), LW'(rv));
        check_val({tag, "_rf_d"}, rf_rsp_dat, rd);
        check_val({tag, "_dma_v"}, LW'(dma_rsp_valid), LW'(dv));
        check_val({tag, "_dma_d"}, dma_rsp_dat, dd);
    endtask

    initial begin
        logic [AW-1:0] a;
        md0_r = {LW{1'b0}};
        md1_r = {LW{1'b0}};
        reset = 1'b1; freeze = 1'b0;
        idle_inputs();

        // Reset: everything low even with both requesters asking
        step();
        rf_req_valid = 1'b1; rf_req_addr = 15'h0011; rf_req_wdat = {LW{1'b1}};
        dma_req_valid = 1'b1; dma_req_we = 1'b1; dma_req_addr = 15'h0022;
        @(negedge clk);
        check_val("rst_rf_rdy", LW'(rf_req_ready), LW'(1'b0));
        check_val("rst_dma_rdy", LW'(dma_req_ready), LW'(1'b0));
        check_val("rst_mem_en", LW'(mem_en), LW'(1'b0));
        check_val("rst_mem_addr", LW'(mem_addr), LW'(15'h0000));
        check_val("rst_mem_wdat", mem_wdat, {LW{1'b0}});
        step();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        check_rsp("idle", 1'b0, {LW{1'b0}}, 1'b0, {LW{1'b0}});

        // Read routing: RF read of 0x0010, data back two cycles later
        step();
        rf_req_valid = 1'b1; rf_req_we = 1'b0; rf_req_addr = 15'h0010;
        @(negedge clk);
        check_val("rd_rf_rdy", LW'(rf_req_ready), LW'(1'b1));
        check_val("rd_mem_en", LW'(mem_en), LW'(1'b1));
        check_val("rd_mem_we", LW'(mem_we), LW'(1'b0));
        check_val("rd_mem_addr", LW'(mem_addr), LW'(15'h0010));
        step();
        idle_inputs();
        @(negedge clk);
        check_rsp("rd_t1", 1'b0, {LW{1'b0}}, 1'b0, {LW{1'b0}});
        step();
        @(negedge clk);
        check_rsp("rd_t2", 1'b1, pat(15'h0010), 1'b0, {LW{1'b0}});
        step();
        @(negedge clk);
        check_rsp("rd_t3", 1'b0, {LW{1'b0}}, 1'b0, {LW{1'b0}});

        // Priority and ordering: RF x3 then DMA, responses RF,RF,RF,DMA
        for (int c = 0; c < 7; c++) begin
            step();
            a = 15'h0021 + AW'(c);
            rf_req_valid = (c < 3); rf_req_we = 1'b0; rf_req_addr = a;
            dma_req_valid = (c <= 3); dma_req_we = 1'b0; dma_req_addr = 15'h0031;
            @(negedge clk);
            check_val($sformatf("pri_rf_rdy%0d", c), LW'(rf_req_ready), LW'(c < 3));
            check_val($sformatf("pri_dma_rdy%0d", c), LW'(dma_req_ready), LW'(c == 3));
            if (c < 3) check_val($sformatf("pri_addr%0d", c), LW'(mem_addr), LW'(a));
            else if (c == 3) check_val("pri_addr3", LW'(mem_addr), LW'(15'h0031));
            else check_val($sformatf("pri_en%0d", c), LW'(mem_en), LW'(1'b0));
            check_rsp($sformatf("pri_rsp%0d", c),
                      (c >= 2 && c <= 4), (c >= 2 && c <= 4) ? pat(15'h0021 + AW'(c - 2)) : {LW{1'b0}},
                      (c == 5), (c == 5) ? pat(15'h0031) : {LW{1'b0}});
        end

        // Continuous contention (writes): starvation relief only when enabled
        for (int c = 0; c < 11; c++) begin
            step();
            rf_req_valid = 1'b1; rf_req_we = 1'b1; rf_req_addr = 15'h0100; rf_req_wdat = LW'(c);
            dma_req_valid = 1'b1; dma_req_we = 1'b1; dma_req_addr = 15'h0200;
`ifdef DCACHE_ARB_STARVE_EN
            @(negedge clk);
            check_val($sformatf("stv_rf_rdy%0d", c), LW'(rf_req_ready), LW'(c != 8));
            check_val($sformatf("stv_dma_rdy%0d", c), LW'(dma_req_ready), LW'(c == 8));
`else
            @(negedge clk);
            check_val($sformatf("stv_rf_rdy%0d", c), LW'(rf_req_ready), LW'(1'b1));
            check_val($sformatf("stv_dma_rdy%0d", c), LW'(dma_req_ready), LW'(1'b0));
`endif
            check_rsp($sformatf("stv_rsp%0d", c), 1'b0, {LW{1'b0}}, 1'b0, {LW{1'b0}});
        end
        step();
        idle_inputs();

        // Freeze: read at T, freeze T+1..T+3, response at T+5
        step();
        rf_req_valid = 1'b1; rf_req_we = 1'b0; rf_req_addr = 15'h0044;
        @(negedge clk);
        check_val("frz_t0_en", LW'(mem_en), LW'(1'b1));
        for (int c = 1; c <= 3; c++) begin
            step();
            freeze = 1'b1;
            rf_req_valid = 1'b1; rf_req_we = 1'b1; rf_req_addr = 15'h0045;
            @(negedge clk);
            check_val($sformatf("frz_en%0d", c), LW'(mem_en), LW'(1'b0));
            check_val($sformatf("frz_rdy%0d", c), LW'({rf_req_ready, dma_req_ready}), LW'(2'b00));
            check_rsp($sformatf("frz_rsp%0d", c), 1'b0, {LW{1'b0}}, 1'b0, {LW{1'b0}});
        end
        step();
        freeze = 1'b0;
        @(negedge clk);
        check_val("frz_t4_we", LW'({mem_en, mem_we}), LW'(2'b11));
        check_rsp("frz_t4", 1'b0, {LW{1'b0}}, 1'b0, {LW{1'b0}});
        step();
        idle_inputs();
        @(negedge clk);
        check_rsp("frz_t5", 1'b1, pat(15'h0044), 1'b0, {LW{1'b0}});

        // Reset mid-flight: DMA read dropped, outputs zero during reset
        step();
        dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = 15'h0055;
        @(negedge clk);
        check_val("rmf_dma_rdy", LW'(dma_req_ready), LW'(1'b1));
        step();
        reset = 1'b1;
        rf_req_valid = 1'b1; dma_req_valid = 1'b1; dma_req_addr = 15'h0056;
        @(negedge clk);
        check_val("rmf_rdy", LW'({rf_req_ready, dma_req_ready}), LW'(2'b00));
        check_val("rmf_mem", LW'({mem_en, mem_we, mem_addr}), LW'(0));
        check_val("rmf_wdat", mem_wdat, {LW{1'b0}});
        check_rsp("rmf_t1", 1'b0, {LW{1'b0}}, 1'b0, {LW{1'b0}});
        step();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        check_rsp("rmf_t2", 1'b0, {LW{1'b0}}, 1'b0, {LW{1'b0}});
        step();
        dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = 15'h0056;
        @(negedge clk);
        check_val("rmf_regrant", LW'({dma_req_ready, mem_en}), LW'(2'b11));
        check_rsp("rmf_t3", 1'b0, {LW{1'b0}}, 1'b0, {LW{1'b0}});
        step();
        idle_inputs();
        @(negedge clk);
        check_rsp("rmf_t4", 1'b0, {LW{1'b0}}, 1'b0, {LW{1'b0}});
        step();
        @(negedge clk);
        check_rsp("rmf_t5", 1'b0, {LW{1'b0}}, 1'b1, pat(15'h0056));

        // DMA write to the top address: same-cycle strobe, no response
        step();
        dma_req_valid = 1'b1; dma_req_we = 1'b1; dma_req_addr = 15'h7FFF; dma_req_wdat = LW'(12'h123);
        @(negedge clk);
        check_val("wr_rdy", LW'(dma_req_ready), LW'(1'b1));
        check_val("wr_en_we", LW'({mem_en, mem_we}), LW'(2'b11));
        check_val("wr_addr", LW'(mem_addr), LW'(15'h7FFF));
        check_val("wr_wdat", mem_wdat, LW'(12'h123));
        step();
        idle_inputs();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_rsp($sformatf("wr_rsp%0d", c), 1'b0, {LW{1'b0}}, 1'b0, {LW{1'b0}});
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Shares the dcache's single memory access port between two requesters: the regfile load/store bus (high priority) and the DMA engine (low priority). Each cycle it grants at most one request and drives the dcache memory port. Read data returns a fixed latency later, and the arbiter routes it back to the requester that issued the read. It sits between the dcache memory array and the memory-stage/DMA pipelines, and it honours the core-wide `freeze` stall.

## Interface
Parameters:
- `ADDR_W`, 15, line address width (10 bits of bank row plus 5 bits of bank select).
- `LINE`, 288, data width per access (18-bit cherryfloat × 16-element tile).
- `MEM_LAT`, 2, memory read latency in cycles, from the issue cycle to `mem_rdat` being valid; legal range 1–4.
- `STARVE_MAX`, 8, number of consecutive denied DMA cycles before DMA is forced to win; legal range 1–15.

Ports:
- `clk`, in, 1, single clock; all state updates on its rising edge.
- `reset`, in, 1, synchronous, active-high.
- `freeze`, in, 1, core stall; while high, no grant, no issue, and the tag pipeline holds.
- `rf_req_valid` / `rf_req_ready`, in / out, 1 / 1, regfile request handshake.
- `rf_req_we`, in, 1, 1 = write, 0 = read.
- `rf_req_addr`, in, `ADDR_W`, regfile request address.
- `rf_req_wdat`, in, `LINE`, regfile write data.
- `rf_rsp_valid`, out, 1, one-cycle pulse; regfile read data valid.
- `rf_rsp_dat`, out, `LINE`, regfile read data.
- `dma_req_valid`, `dma_req_ready`, `dma_req_we`, `dma_req_addr`, `dma_req_wdat`, `dma_rsp_valid`, `dma_rsp_dat`: same shapes and meanings, for the DMA requester.
- `mem_en`, out, 1, memory access strobe.
- `mem_we`, out, 1, memory write enable.
- `mem_addr`, out, `ADDR_W`, memory address.
- `mem_wdat`, out, `LINE`, memory write data.
- `mem_rdat`, in, `LINE`, memory read data, valid `MEM_LAT` cycles after a read is issued.

## Operation
- **Handshake:** a request transfers on a cycle where `valid && ready`.
  - `ready` is combinational from the current inputs and state.
  - At most one of the two `ready` signals is high in any cycle.
  - A requester must hold `valid`, `we`, `addr` and `wdat` stable until the transfer.
- **Grant rule:** both `ready` signals are low while `freeze` or `reset` is high. Otherwise:
  - regfile wins if `rf_req_valid`;
  - else DMA wins if `dma_req_valid`;
  - with `DCACHE_ARB_STARVE_EN` defined, the starvation rule below overrides this.
- **Memory drive:** on a transfer, `mem_en`, `mem_we`, `mem_addr` and `mem_wdat` are driven combinationally from the winner in the same cycle. With no transfer, `mem_en = 0` and `mem_we = 0`.
- **Tag pipeline:** a `MEM_LAT`-deep shift register of `{valid, owner}` entries.
  - Every read transfer pushes `{1, owner}`; any other cycle pushes `{0, x}`.
  - The entry at the pipeline output raises the owner's `rsp_valid` for exactly one cycle.
  - The owner's `rsp_dat` is driven with `mem_rdat` on that cycle.
  - The non-owner's `rsp_dat` is 0.
- **Writes:** produce no response.
- **Ordering:** responses return in grant order. There is no response backpressure; requesters must always accept a response.
- **Freeze:** the dcache memory shares `freeze`, so its read pipeline holds too. While `freeze` is high:
  - the tag pipeline does not shift;
  - both `rsp_valid` signals are forced to 0;
  - a pending head response is presented in the first unfrozen cycle.
- **Reset:** on a cycle with `reset` high, all state clears on the next edge:
  - tag pipeline cleared, so in-flight reads are dropped with no response;
  - starvation counter set to 0.

  All outputs are 0 during reset.

## Timing
- Issue latency is 0 cycles: the request cycle is the memory strobe cycle.
- A read transferred in cycle T produces `rsp_valid` in cycle T+`MEM_LAT`, plus the number of frozen cycles in between.
- Throughput is one access per cycle.
- Back-to-back reads from different owners return in consecutive cycles to the correct owners.
- A reset asserted mid-flight suppresses every response due in or after the first reset cycle.

## Configuration
- Macro: `DCACHE_ARB_STARVE_EN`.
- **Defined:** a 4-bit counter increments on each unfrozen cycle in which `dma_req_valid && !dma_req_ready`.
  - When the counter equals `STARVE_MAX`, DMA wins the next unfrozen cycle even if `rf_req_valid` is high.
  - The counter clears on any DMA transfer, and whenever `dma_req_valid` is low.
  - The counter holds during `freeze`.
- **Undefined:** strict fixed priority; no counter is present, and DMA can starve indefinitely.

## Structure
- Shared package `dcache_pkg`:
  - `typedef enum logic {OWNER_RF, OWNER_DMA} dcache_owner_t`;
  - `typedef struct packed {logic valid; dcache_owner_t owner;} dcache_tag_t`;
  - defaults for `ADDR_W` and `LINE`.
- One sub-module, `dcache_rsp_tag_pipe`: a parameterised depth-`MEM_LAT` shift register of `dcache_tag_t` with shift-enable (`!freeze`) and synchronous clear.

## Test plan
- **Read routing:** RF read of addr 0x0010 at T, with the memory model returning 0xAAA… → `mem_en=1, mem_we=0, mem_addr=0x0010` at T; `rf_rsp_valid=1` with data 0xAAA… at T+2; `dma_rsp_valid` stays 0.
- **Priority and ordering:** RF and DMA both valid for 3 cycles, all reads → RF granted 3 times, DMA held; RF drops → DMA granted on the 4th cycle; responses return RF, RF, RF, DMA in cycles 3–6 relative to start.
- **Starvation (STARVE_EN, `STARVE_MAX=8`):** RF and DMA valid continuously → DMA denied 8 cycles, granted on cycle 9 with `rf_req_ready=0`; RF resumes on cycle 10; counter back at 0.
- **Freeze:** read at T, `freeze` high T+1..T+3 → `mem_en=0` and both `ready` low during freeze; `rf_rsp_valid` at T+5, not earlier.
- **Reset mid-flight:** DMA read at T, `reset` at T+1 → no `dma_rsp_valid` ever; all outputs 0 during T+1; the first grant after reset releases behaves normally.
- **Write:** DMA write of 0x123 to addr 0x7FFF → `mem_we=1, mem_wdat=0x123` the same cycle; no response on either port.
